// File: rtl/uart_pkg.sv
// Shared UART definitions: TX buffer FSM states, data width, register map and control bits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // TX buffer handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BUSY = 2'd2
  } txbuf_state_t;

  localparam int UART_DATA_W = 8;

  // APB register offsets inside the UART peripheral
  localparam logic [7:0] UART_CTRL_OFS   = 8'h00;
  localparam logic [7:0] UART_CFG_OFS    = 8'h04;
  localparam logic [7:0] UART_TXDATA_OFS = 8'h0C;

  // Control register bit positions
  localparam int CTRL_TX_EN_BIT = 1;
  localparam int CTRL_RX_EN_BIT = 0;

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// sync_fifo: generic synchronous FIFO with wrapping pointers, occupancy counter and registered flags.
// Latency: an accepted push shows in level/empty/head_data the following cycle.
// Backpressure: none internally; the caller only pushes when not full (or while popping) and only pops when not empty.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_nxt;

  // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Pointers wrap naturally modulo DEPTH (power of two); flags are registered from the next level
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == FULL_LVL);
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Show-ahead read: the head entry is presented without a read request
  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: queues TX data register writes and releases one byte per frame to the UART transmitter.
// Latency: write in N -> level/empty in N+1, uart_send in N+2 if idle and enabled; next uart_send 2 cycles after uart_tx_done.
// Backpressure: none to the writer; a write to a full buffer with no pop is dropped (sticky ovf when UART_TXBUF_OVF_EN is defined).
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    tx_enable,
  input  logic                    uart_tx_active,
  input  logic                    uart_tx_done,
  output logic                    uart_send,
  output logic [DATA_W-1:0]       uart_data_in,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
`ifdef UART_TXBUF_OVF_EN
  ,
  output logic                    ovf,
  input  logic                    ovf_clr
`endif
);

  txbuf_state_t      state_q;
  txbuf_state_t      state_nxt;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] fifo_head;
  logic              send_nxt;
  logic [DATA_W-1:0] data_nxt;

  // A new byte leaves the queue only from IDLE, with the line free and transmission enabled
  assign pop  = (state_q == IDLE) && !empty && tx_enable && !uart_tx_active;
  // When full, a write is still taken if a pop frees a slot in the same cycle
  assign push = wr_en && (!full || pop);

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // FSM state register
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_nxt;
  end

  // Next state: a frame in flight always completes, tx_enable only gates the next pop
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (pop) state_nxt = SEND;
      SEND:    state_nxt = BUSY;
      BUSY:    if (uart_tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next outputs: send pulse is high for the SEND cycle only; data captured at pop and held through BUSY
  always_comb begin
    send_nxt = (state_nxt == SEND);
    data_nxt = uart_data_in;
    if (pop) data_nxt = fifo_head;
  end

  // Output register keeps every transmitter-facing output free of combinational input paths
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      uart_send    <= 1'b0;
      uart_data_in <= '0;
    end else begin
      uart_send    <= send_nxt;
      uart_data_in <= data_nxt;
    end
  end

`ifdef UART_TXBUF_OVF_EN
  logic drop;
  assign drop = wr_en && full && !pop;

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)    ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: directed scenarios with random payloads against a byte-queue model
// and a behavioural transmitter (fixed frame length, one-cycle done pulse).
// Build with UART_TXBUF_OVF_EN defined to include the overflow flag checks.
module tb_uart_tx_buffer;

  localparam int DEPTH = 8;
  localparam int FRAME = 20;

  logic       aclk = 1'b0;
  logic       areset_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_enable = 1'b0;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       uart_send;
  logic [7:0] uart_data_in;
  logic       full;
  logic       empty;
  logic [3:0] level;
`ifdef UART_TXBUF_OVF_EN
  logic       ovf;
  logic       ovf_clr = 1'b0;
`endif

  uart_tx_buffer #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .aclk           (aclk),
    .areset_n       (areset_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .tx_enable      (tx_enable),
    .uart_tx_active (tx_active),
    .uart_tx_done   (tx_done),
    .uart_send      (uart_send),
    .uart_data_in   (uart_data_in),
    .full           (full),
    .empty          (empty),
    .level          (level)
`ifdef UART_TXBUF_OVF_EN
    ,
    .ovf            (ovf),
    .ovf_clr        (ovf_clr)
`endif
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: bytes accepted by the buffer and not yet seen on the line, in order
  logic [7:0] fifo_m[$];
  int         send_cnt = 0;
  int         cyc = 0;
  int         last_done_cyc = 0;
  bit         have_done = 1'b0;
  int         frame_left = 0;
  logic [7:0] cur_byte = 8'h00;
  int         peak = 0;

  // Behavioural transmitter plus send monitor, evaluated 1 time unit after each rising edge
  always @(posedge aclk) begin
    logic [7:0] exp_b;
    #1;
    cyc++;
    if (!areset_n) begin
      tx_active  = 1'b0;
      tx_done    = 1'b0;
      frame_left = 0;
      have_done  = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (tx_active) begin
        check("send_one_cycle", 32'(uart_send), 32'd0);
        frame_left--;
        if (frame_left == 0) begin
          tx_active = 1'b0;
          tx_done   = 1'b1;
          check("data_held_to_done", 32'(uart_data_in), 32'(cur_byte));
          last_done_cyc = cyc;
          have_done     = 1'b1;
        end
      end else if (uart_send) begin
        send_cnt++;
        check("send_has_queued_byte", 32'(fifo_m.size() > 0), 32'd1);
        exp_b = (fifo_m.size() > 0) ? fifo_m.pop_front() : 8'hxx;
        check("send_data", 32'(uart_data_in), 32'(exp_b));
        if (have_done) check("send_spacing", 32'((cyc - last_done_cyc) >= 2), 32'd1);
        cur_byte   = uart_data_in;
        tx_active  = 1'b1;
        frame_left = FRAME;
      end
      if (int'(level) > peak) peak = int'(level);
    end
  end

  // Inputs are driven 2 time units after the edge, clear of the transmitter model
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic write(input logic [7:0] d, input bit pop_same_cycle);
    wr_en   = 1'b1;
    wr_data = d;
    if (fifo_m.size() < DEPTH || pop_same_cycle) fifo_m.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_sends(input int target, input int budget);
    int n = 0;
    while (send_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("send_count", 32'(send_cnt), 32'(target));
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (tx_active && n < FRAME + 5) begin
      tick();
      n++;
    end
    check("tx_quiet", 32'(tx_active), 32'd0);
  endtask

  initial begin
    int base;
    logic [7:0] b;

    // Reset values
    #3 areset_n = 1'b0;
    tick(); tick();
    check("rst_send", 32'(uart_send), 32'd0);
    check("rst_data", 32'(uart_data_in), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
`ifdef UART_TXBUF_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    areset_n = 1'b1;
    tick();

    // Single byte: level in N+1, uart_send in N+2
    tx_enable = 1'b1;
    tick();
    write(8'hEF, 1'b0);
    check("single_level_n1", 32'(level), 32'd1);
    check("single_empty_n1", 32'(empty), 32'd0);
    check("single_send_n1", 32'(uart_send), 32'd0);
    tick();
    check("single_send_n2", 32'(uart_send), 32'd1);
    check("single_data_n2", 32'(uart_data_in), 32'hEF);
    wait_quiet();
    tick(); tick();
    check("single_empty_after", 32'(empty), 32'd1);

    // Three back-to-back writes
    peak = 0;
    base = send_cnt;
    write(8'hEF, 1'b0);
    write(8'hAA, 1'b0);
    write(8'hBB, 1'b0);
    wait_sends(base + 3, 4 * (FRAME + 4));
    wait_quiet();
    tick(); tick(); tick();
    check("b2b_peak_level", 32'(peak), 32'd2);
    check("b2b_empty", 32'(empty), 32'd1);

    // Fill while disabled: ninth byte dropped
    tx_enable = 1'b0;
    for (int i = 0; i < 9; i++) write(8'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_level", 32'(level), 32'd8);
    check("fill_level_model", 32'(level), 32'(fifo_m.size()));
    check("fill_empty", 32'(empty), 32'd0);
`ifdef UART_TXBUF_OVF_EN
    check("fill_ovf_set", 32'(ovf), 32'd1);
`endif

    // Re-enable together with a write: push alongside the pop keeps the buffer full
    base = send_cnt;
    tx_enable = 1'b1;
    write(8'h55, 1'b1);
    check("fullpop_level", 32'(level), 32'd8);
    check("fullpop_full", 32'(full), 32'd1);
    wait_sends(base + 9, 10 * (FRAME + 4));
    wait_quiet();
    tick(); tick(); tick();
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_model_empty", 32'(fifo_m.size()), 32'd0);
`ifdef UART_TXBUF_OVF_EN
    check("ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
`endif

    // Disable during BUSY: the frame completes, the rest stays queued
    base = send_cnt;
    for (int i = 0; i < 3; i++) write(8'($urandom()), 1'b0);
    wait_sends(base + 1, FRAME);
    tick(); tick(); tick();
    tx_enable = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) tick();
    check("disabled_no_send", 32'(send_cnt), 32'(base + 1));
    check("disabled_level", 32'(level), 32'd2);
    tx_enable = 1'b1;
    wait_sends(base + 3, 3 * (FRAME + 4));
    wait_quiet();
    tick(); tick(); tick();
    check("resume_empty", 32'(empty), 32'd1);

    // Random payloads with random gaps
    base = send_cnt;
    for (int i = 0; i < 8; i++) begin
      write(8'($urandom()), 1'b0);
      for (int g = $urandom_range(0, 25); g > 0; g--) tick();
    end
    wait_sends(base + 8, 9 * (FRAME + 4));
    wait_quiet();
    tick(); tick(); tick();
    check("rand_empty", 32'(empty), 32'd1);
    check("rand_level", 32'(level), 32'd0);

    // Reset mid-BUSY with three bytes queued
    base = send_cnt;
    for (int i = 0; i < 4; i++) begin
      b = 8'h80 | 8'($urandom());
      write(b, 1'b0);
    end
    tick(); tick(); tick(); tick(); tick();
    check("pre_rst_level", 32'(level), 32'd3);
    check("pre_rst_busy", 32'(tx_active), 32'd1);
    @(posedge aclk);
    #3 areset_n = 1'b0;
    #1;
    check("midrst_send", 32'(uart_send), 32'd0);
    check("midrst_data", 32'(uart_data_in), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full", 32'(full), 32'd0);
    fifo_m.delete();
    tick(); tick(); tick();
    areset_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) tick();
    check("postrst_no_send", 32'(send_cnt), 32'(base + 1));
    check("postrst_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
